// File: rtl/fp_writeback_arbiter.sv
// fp_writeback_arbiter
// Write side of the FP physical register file. Merges the fixed-latency FP
// pipe (priority) and the variable-latency div/sqrt unit (buffered in a
// small circular FIFO) onto one register-file write port. It also raises the
// matching active-list completion strobe.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall               backend stall: no dequeue, no write, no cut-through
//   flush_all           drop buffered and incoming results
//   pipe_*              FP pipe result (valid, dst, data, alptr)
//   div_*               div/sqrt result with valid/ready handshake
//   wr_en/wr_dst/wr_data  registered register-file write port
//   done_valid/done_alptr registered active-list completion
//   buf_count           div FIFO occupancy
//
// Optional: define FP_WB_PERF_COUNTER_EN to add perf_div_wait_cycles and
// perf_div_cutthrough (32-bit saturating counters).
module fp_writeback_arbiter #(
  parameter int unsigned PREG_W        = 7,
  parameter int unsigned DATA_W        = 64,
  parameter int unsigned ALPTR_W       = 6,
  parameter int unsigned DIV_BUF_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic                             flush_all,
  input  logic                             pipe_valid,
  input  logic [PREG_W-1:0]                pipe_dst,
  input  logic [DATA_W-1:0]                pipe_data,
  input  logic [ALPTR_W-1:0]               pipe_alptr,
  input  logic                             div_valid,
  output logic                             div_ready,
  input  logic [PREG_W-1:0]                div_dst,
  input  logic [DATA_W-1:0]                div_data,
  input  logic [ALPTR_W-1:0]               div_alptr,
  output logic                             wr_en,
  output logic [PREG_W-1:0]                wr_dst,
  output logic [DATA_W-1:0]                wr_data,
  output logic                             done_valid,
  output logic [ALPTR_W-1:0]               done_alptr,
  output logic [$clog2(DIV_BUF_DEPTH):0]   buf_count
`ifdef FP_WB_PERF_COUNTER_EN
  ,
  output logic [31:0]                      perf_div_wait_cycles,
  output logic [31:0]                      perf_div_cutthrough
`endif
);

  localparam int unsigned PTR_W = $clog2(DIV_BUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PREG_W-1:0]  dst;
    logic [DATA_W-1:0]  data;
    logic [ALPTR_W-1:0] alptr;
  } wb_entry_t;

  wb_entry_t        mem [DIV_BUF_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  wb_entry_t pipe_entry;
  wb_entry_t div_entry;
  wb_entry_t sel;
  logic      sel_valid;
  logic      push;
  logic      pop;
  logic      cut;
  logic      div_accept;

  assign pipe_entry = '{dst: pipe_dst, data: pipe_data, alptr: pipe_alptr};
  assign div_entry  = '{dst: div_dst,  data: div_data,  alptr: div_alptr};

  // Ready depends only on registered occupancy and the flush strobe.
  assign div_ready  = (count < CNT_W'(DIV_BUF_DEPTH)) && !flush_all;
  assign div_accept = div_valid && div_ready;
  assign buf_count  = count;

  // Source selection: pipe > FIFO head > cut-through of an incoming div result.
  always_comb begin
    sel_valid = 1'b0;
    sel       = '0;
    pop       = 1'b0;
    cut       = 1'b0;
    push      = 1'b0;
    if (!flush_all) begin
      if (!stall) begin
        if (pipe_valid) begin
          sel_valid = 1'b1;
          sel       = pipe_entry;
        end else if (count != '0) begin
          sel_valid = 1'b1;
          sel       = mem[head];
          pop       = 1'b1;
        end else if (div_valid) begin
          sel_valid = 1'b1;
          sel       = div_entry;
          cut       = 1'b1;
        end
      end
      // A cut-through result goes straight to the port, never into the FIFO.
      push = div_accept && !cut;
    end
  end

  // FIFO pointers, occupancy and registered write/completion port.
  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      wr_en      <= 1'b0;
      wr_dst     <= '0;
      wr_data    <= '0;
      done_valid <= 1'b0;
      done_alptr <= '0;
    end else begin
      if (flush_all) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + PTR_W'(1);
        if (pop)  head <= head + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
      wr_en      <= sel_valid;
      done_valid <= sel_valid;
      wr_dst     <= sel.dst;
      wr_data    <= sel.data;
      done_alptr <= sel.alptr;
    end
  end

  // FIFO storage; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= div_entry;
  end

`ifdef FP_WB_PERF_COUNTER_EN
  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_div_wait_cycles <= '0;
      perf_div_cutthrough  <= '0;
    end else begin
      if ((count != '0) && !pop && (perf_div_wait_cycles != '1))
        perf_div_wait_cycles <= perf_div_wait_cycles + 32'd1;
      if (cut && (perf_div_cutthrough != '1))
        perf_div_cutthrough <= perf_div_cutthrough + 32'd1;
    end
  end
`endif

  // Upstream must hold the pipe idle while the backend is stalled.
  a_no_pipe_during_stall: assert property (
    @(posedge clk) disable iff (rst) (stall && !flush_all) |-> !pipe_valid);

endmodule

// File: tb/tb_fp_writeback_arbiter.sv
module tb_fp_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush_all;
  logic        pipe_valid;
  logic [6:0]  pipe_dst;
  logic [63:0] pipe_data;
  logic [5:0]  pipe_alptr;
  logic        div_valid;
  logic        div_ready;
  logic [6:0]  div_dst;
  logic [63:0] div_data;
  logic [5:0]  div_alptr;
  logic        wr_en;
  logic [6:0]  wr_dst;
  logic [63:0] wr_data;
  logic        done_valid;
  logic [5:0]  done_alptr;
  logic [1:0]  buf_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0]  dst;
    logic [63:0] data;
    logic [5:0]  alptr;
  } exp_t;

  exp_t exp_q[$];

  fp_writeback_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush_all  (flush_all),
    .pipe_valid (pipe_valid),
    .pipe_dst   (pipe_dst),
    .pipe_data  (pipe_data),
    .pipe_alptr (pipe_alptr),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_dst    (div_dst),
    .div_data   (div_data),
    .div_alptr  (div_alptr),
    .wr_en      (wr_en),
    .wr_dst     (wr_dst),
    .wr_data    (wr_data),
    .done_valid (done_valid),
    .done_alptr (done_alptr),
    .buf_count  (buf_count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mkdata(input logic [6:0] d);
    return 64'hC0DE_0000_0000_0000 | 64'(d);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_valid = 1'b0; pipe_dst = '0; pipe_data = '0; pipe_alptr = '0;
    div_valid  = 1'b0; div_dst  = '0; div_data  = '0; div_alptr  = '0;
  endtask

  task automatic drive_pipe(input logic [6:0] d, input logic [63:0] data, input logic [5:0] a);
    pipe_valid = 1'b1; pipe_dst = d; pipe_data = data; pipe_alptr = a;
  endtask

  task automatic drive_div(input logic [6:0] d, input logic [63:0] data, input logic [5:0] a);
    div_valid = 1'b1; div_dst = d; div_data = data; div_alptr = a;
  endtask

  task automatic expect_wr(input logic [6:0] d, input logic [63:0] data, input logic [5:0] a);
    exp_t e;
    e.dst = d; e.data = data; e.alptr = a;
    exp_q.push_back(e);
  endtask

  // Monitor: every presented write must match the next expected write in order.
  always @(negedge clk) begin
    exp_t e;
    if (wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got dst %0d alptr %0d, required no write", wr_dst, done_alptr);
      end else begin
        e = exp_q.pop_front();
        if (wr_dst !== e.dst || wr_data !== e.data || done_alptr !== e.alptr || done_valid !== 1'b1) begin
          errors++;
          $display("FAIL write_match: got dst %0d data %0h alptr %0d done %b, required dst %0d data %0h alptr %0d done 1",
                   wr_dst, wr_data, done_alptr, done_valid, e.dst, e.data, e.alptr);
        end
      end
    end else if (done_valid === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_without_write: got done_valid 1, required 0");
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_wr_en"},      64'(wr_en),      64'd0);
    check({tag, "_done_valid"}, 64'(done_valid), 64'd0);
    check({tag, "_wr_dst"},     64'(wr_dst),     64'd0);
    check({tag, "_wr_data"},    wr_data,         64'd0);
    check({tag, "_done_alptr"}, 64'(done_alptr), 64'd0);
    check({tag, "_buf_count"},  64'(buf_count),  64'd0);
    check({tag, "_div_ready"},  64'(div_ready),  64'd1);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush_all = 1'b0;
    idle();
    repeat (3) tick();
    rst = 1'b0;
    check_reset_state("reset");

    // Pipe-only write.
    drive_pipe(7'd5, 64'h3FF0_0000_0000_0000, 6'd3);
    expect_wr(7'd5, 64'h3FF0_0000_0000_0000, 6'd3);
    tick(); idle();
    check("pipe_only_wr_en", 64'(wr_en), 64'd1);
    check("pipe_only_buf_count", 64'(buf_count), 64'd0);
    tick();

    // Cut-through with empty FIFO.
    drive_div(7'd9, mkdata(7'd9), 6'd7);
    check("cut_div_ready", 64'(div_ready), 64'd1);
    expect_wr(7'd9, mkdata(7'd9), 6'd7);
    tick(); idle();
    check("cut_wr_dst", 64'(wr_dst), 64'd9);
    check("cut_buf_count", 64'(buf_count), 64'd0);
    tick();

    // Collision: pipe wins, div buffered, written after next pipe op.
    drive_pipe(7'd1, mkdata(7'd1), 6'd11);
    drive_div(7'd2, mkdata(7'd2), 6'd12);
    expect_wr(7'd1, mkdata(7'd1), 6'd11);
    expect_wr(7'd3, mkdata(7'd3), 6'd13);
    expect_wr(7'd2, mkdata(7'd2), 6'd12);
    tick(); idle();
    drive_pipe(7'd3, mkdata(7'd3), 6'd13);
    check("coll_count_t1", 64'(buf_count), 64'd1);
    tick(); idle();
    check("coll_count_t2", 64'(buf_count), 64'd1);
    check("coll_wr_dst_t2", 64'(wr_dst), 64'd3);
    tick();
    check("coll_count_t3", 64'(buf_count), 64'd0);
    check("coll_wr_dst_t3", 64'(wr_dst), 64'd2);
    tick();

    // Full / back-pressure: pipe busy for 4 cycles, div offers 10, 11, 12.
    for (int i = 0; i < 4; i++) expect_wr(7'(20 + i), mkdata(7'(20 + i)), 6'(20 + i));
    for (int i = 0; i < 3; i++) expect_wr(7'(10 + i), mkdata(7'(10 + i)), 6'(30 + i));
    drive_pipe(7'd20, mkdata(7'd20), 6'd20); drive_div(7'd10, mkdata(7'd10), 6'd30);
    check("full_ready_a0", 64'(div_ready), 64'd1);
    tick();
    drive_pipe(7'd21, mkdata(7'd21), 6'd21); drive_div(7'd11, mkdata(7'd11), 6'd31);
    check("full_ready_a1", 64'(div_ready), 64'd1);
    tick();
    drive_pipe(7'd22, mkdata(7'd22), 6'd22); drive_div(7'd12, mkdata(7'd12), 6'd32);
    check("full_ready_a2", 64'(div_ready), 64'd0);
    check("full_count_a2", 64'(buf_count), 64'd2);
    tick();
    drive_pipe(7'd23, mkdata(7'd23), 6'd23);
    check("full_ready_a3", 64'(div_ready), 64'd0);
    tick();
    pipe_valid = 1'b0;
    check("full_ready_a4", 64'(div_ready), 64'd0);
    tick();
    check("full_ready_a5", 64'(div_ready), 64'd1);
    check("full_wr_dst_a5", 64'(wr_dst), 64'd10);
    tick(); idle();
    check("full_wr_dst_a6", 64'(wr_dst), 64'd11);
    check("full_count_a6", 64'(buf_count), 64'd1);
    tick();
    check("full_wr_dst_a7", 64'(wr_dst), 64'd12);
    check("full_count_a7", 64'(buf_count), 64'd0);
    tick();

    // Flush with two buffered entries; flush-cycle inputs ignored.
    drive_pipe(7'd30, mkdata(7'd30), 6'd1); drive_div(7'd40, mkdata(7'd40), 6'd2);
    expect_wr(7'd30, mkdata(7'd30), 6'd1);
    tick();
    drive_pipe(7'd31, mkdata(7'd31), 6'd3); drive_div(7'd41, mkdata(7'd41), 6'd4);
    expect_wr(7'd31, mkdata(7'd31), 6'd3);
    tick();
    drive_pipe(7'd32, mkdata(7'd32), 6'd5); drive_div(7'd42, mkdata(7'd42), 6'd6);
    flush_all = 1'b1;
    check("flush_count_before", 64'(buf_count), 64'd2);
    check("flush_div_ready", 64'(div_ready), 64'd0);
    tick(); idle(); flush_all = 1'b0;
    check("flush_count_after", 64'(buf_count), 64'd0);
    check("flush_wr_en", 64'(wr_en), 64'd0);
    tick();
    check("flush_wr_en_later", 64'(wr_en), 64'd0);
    tick();

    // Stall with one buffered entry.
    drive_pipe(7'd50, mkdata(7'd50), 6'd8); drive_div(7'd60, mkdata(7'd60), 6'd9);
    expect_wr(7'd50, mkdata(7'd50), 6'd8);
    expect_wr(7'd60, mkdata(7'd60), 6'd9);
    tick(); idle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_wr_en", 64'(wr_en), 64'd0);
    end
    stall = 1'b0;
    check("stall_count_held", 64'(buf_count), 64'd1);
    tick();
    check("stall_release_wr_en", 64'(wr_en), 64'd1);
    check("stall_release_wr_dst", 64'(wr_dst), 64'd60);
    tick();

    // Reset mid-operation with two buffered entries.
    drive_pipe(7'd70, mkdata(7'd70), 6'd14); drive_div(7'd80, mkdata(7'd80), 6'd15);
    expect_wr(7'd70, mkdata(7'd70), 6'd14);
    tick();
    drive_pipe(7'd71, mkdata(7'd71), 6'd16); drive_div(7'd81, mkdata(7'd81), 6'd17);
    expect_wr(7'd71, mkdata(7'd71), 6'd16);
    tick(); idle();
    check("rst_count_before", 64'(buf_count), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("midrst");
    tick();
    check("midrst_no_write", 64'(wr_en), 64'd0);
    repeat (4) tick();

    check("drain_expected_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_writeback_arbiter.md
Name: fp_writeback_arbiter

Overview:
- Write side of the FP physical register file, the counterpart of the FP register-read stage.
- Merges two result sources onto one FP register-file write port:
  - the fixed-latency FP pipe (FMA/add/mul/cvt), which has priority;
  - the variable-latency FP div/sqrt unit, whose results are buffered in a small FIFO until a write slot is free.
- Also drives the writeback-valid/ready bit and the active-list completion for each written op.

Parameters:
- PREG_W, 7, physical register number width
- DATA_W, 64, FP register data width
- ALPTR_W, 6, active-list pointer width
- DIV_BUF_DEPTH, 2, div result FIFO depth (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  backend stall
- flush_all  in  1  discard all buffered and incoming results
- pipe_valid  in  1  FP pipe result valid
- pipe_dst  in  PREG_W  pipe destination preg
- pipe_data  in  DATA_W  pipe result
- pipe_alptr  in  ALPTR_W  pipe active-list pointer
- div_valid  in  1  div/sqrt result valid
- div_ready  out  1  FIFO can accept a div result
- div_dst  in  PREG_W  div destination preg
- div_data  in  DATA_W  div result
- div_alptr  in  ALPTR_W  div active-list pointer
- wr_en  out  1  register-file write enable
- wr_dst  out  PREG_W  write preg number
- wr_data  out  DATA_W  write data; the preg valid bit is set with it
- done_valid  out  1  active-list completion strobe
- done_alptr  out  ALPTR_W  completed op pointer
- buf_count  out  $clog2(DIV_BUF_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset:
  - FIFO emptied (head = tail = 0, count = 0).
  - wr_en = 0, done_valid = 0, wr_dst/wr_data/done_alptr = 0.
  - div_ready = 1 from the first cycle after reset.
- All write-port and completion outputs are registered: a source selected in cycle T appears on wr_* / done_* in cycle T+1.
- done_valid == wr_en, and done_alptr carries the same op, in the same cycle.
- Div handshake:
  - A div result is accepted in cycle T iff div_valid && div_ready.
  - div_ready = (count < DIV_BUF_DEPTH) && !flush_all, combinational from registered count.
  - The div unit holds its result until accepted.
- Arbitration in cycle T, when !stall && !flush_all:
  1. If pipe_valid: select the pipe result. The FIFO is not dequeued. An accepted div result is enqueued.
  2. Else if count > 0: select and dequeue the FIFO head. An accepted div result is enqueued in the same cycle (simultaneous push/pop; count unchanged).
  3. Else if div_valid (FIFO empty): cut-through. Select the div result directly; it is not enqueued.
  4. Else: wr_en = 0 next cycle.
- Stall:
  - No dequeue, and wr_en = 0 next cycle.
  - Div results may still be enqueued if not full; cut-through is disabled.
  - pipe_valid during stall is a protocol error and is checked by assertion. Upstream guarantees it is 0.
- flush_all:
  - FIFO cleared next cycle.
  - pipe/div inputs in that cycle are ignored.
  - wr_en = 0 next cycle.
  - flush_all has priority over stall.
- FIFO:
  - Circular with wrap-around of head/tail modulo DIV_BUF_DEPTH.
  - Push when full cannot occur, because div_ready = 0.
  - Pop when empty never occurs.
- Reset mid-operation discards all buffered results, and no write is issued the following cycle.
- Writes only ever come from valid sources. The same preg is never written twice for one accepted result.

Optional Feature:
- Macro FP_WB_PERF_COUNTER_EN adds outputs:
  - perf_div_wait_cycles (32b): counts cycles with count > 0 and no dequeue.
  - perf_div_cutthrough (32b): counts cut-through writes.
- Both counters are cleared by rst and saturate at all-ones.
- Without the macro, the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Pipe-only: pipe_valid with dst=5, data=0x3FF0000000000000, alptr=3 at T -> wr_en=1, wr_dst=5, same data at T+1; done_valid=1, done_alptr=3; buf_count stays 0.
- Cut-through: FIFO empty, div_valid with dst=9, alptr=7, no pipe at T -> div_ready=1, wr_dst=9 at T+1, buf_count stays 0.
- Collision: pipe (dst=1) and div (dst=2) valid at T, pipe (dst=3) at T+1 -> wr_dst=1 at T+1, wr_dst=3 at T+2, wr_dst=2 at T+3; buf_count = 1 during T+1..T+2.
- Full/back-pressure: pipe_valid held high 4 cycles while div offers 3 results (dst 10, 11, 12) -> div_ready=0 after 2 are accepted; dst 12 is held; after the pipe idles, writes occur in order 10, 11, 12 on consecutive cycles.
- Flush: FIFO holds 2 entries, flush_all for 1 cycle -> buf_count=0, wr_en=0 next cycle, no write of the buffered dst ever appears.
- Stall and reset: FIFO holds 1 entry, stall held 3 cycles -> wr_en=0 throughout, entry written the cycle after stall drops; asserting rst with 2 entries buffered -> all outputs 0 and div_ready=1 after reset.
